// File: rtl/hdmi_pkg.sv
// hdmi_pkg: shared cs codes, resolution codes, pattern table and scheduler states.
package hdmi_pkg;
  localparam logic [3:0] CS_NONE     = 4'h0;
  localparam logic [3:0] CS_COLORBAR = 4'h9;
  localparam logic [3:0] CS_GRID     = 4'hA;
  localparam logic [3:0] CS_GRAY     = 4'hB;
  localparam logic [3:0] CS_SOLID    = 4'hC;
  localparam logic [1:0] RES_640x480  = 2'b00;
  localparam logic [1:0] RES_1024x768 = 2'b01;
  localparam logic [1:0] RES_800x600  = 2'b10;
  typedef enum logic [1:0] {S_RUN, S_WAIT, S_TGRST, S_BLANK} state_t;
  function automatic logic [3:0] pattern_cs(input logic [1:0] idx);
    return idx == 2'd0 ? CS_COLORBAR : idx == 2'd1 ? CS_GRID : idx == 2'd2 ? CS_GRAY : CS_SOLID;
  endfunction
endpackage

// File: rtl/hdmi_sched_frame_cnt.sv
// hdmi_sched_frame_cnt: modulo-MOD frame counter with enable, clear and terminal count.
module hdmi_sched_frame_cnt #(
  parameter int MOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc
);
  localparam int W = MOD > 1 ? $clog2(MOD) : 1;
  logic [W-1:0] cnt;
  assign tc = cnt == W'(MOD - 1);
  always_ff @(posedge clk)
    if (!rst_n || clr) cnt <= '0;
    else if (en) cnt <= tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/hdmi_pattern_sched.sv
// hdmi_pattern_sched: pattern rotation and safe resolution-switch sequencing.
// Optional HDMI_SCHED_HOLD_EN adds a hold input that freezes rotation in S_RUN.
module hdmi_pattern_sched
  import hdmi_pkg::*;
#(
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int NUM_PATTERNS       = 4,
  parameter int BLANK_FRAMES       = 2,
  parameter int TG_RST_CYCLES      = 16
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       frame_start,
  input  logic       auto_en,
  input  logic       next_req,
  input  logic       res_req,
  input  logic [1:0] res_code_in,
`ifdef HDMI_SCHED_HOLD_EN
  input  logic       hold,
`endif
  output logic [3:0] cs,
  output logic [1:0] resolution_code,
  output logic       timing_rst_n,
  output logic       busy
);
  localparam int RW = TG_RST_CYCLES > 1 ? $clog2(TG_RST_CYCLES) : 1;
`ifndef HDMI_SCHED_HOLD_EN
  logic hold;
  assign hold = 1'b0;
`endif
  state_t state, state_nx;
  logic [1:0] idx, idx_nx, res_nx, target, target_nx, norm, idx_adv;
  logic [3:0] cs_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic trst_nx, busy_nx, pend, pend_nx;
  logic run, res_take, fs_ok, advance, keep_adv, rot_tc, blank_tc, blank_done, run_back;
  assign norm       = res_code_in == 2'b11 ? RES_640x480 : res_code_in;
  assign run        = state == S_RUN;
  assign res_take   = run & res_req & (norm != resolution_code);
  assign fs_ok      = run & frame_start & ~hold & ~res_take;
  assign advance    = fs_ok & ((auto_en & rot_tc) | pend | next_req);
  // a terminal count lost to a same-cycle switch request is remembered as a pending advance
  assign keep_adv   = res_take & frame_start & ~hold & auto_en & rot_tc;
  assign idx_adv    = idx == 2'(NUM_PATTERNS - 1) ? 2'd0 : idx + 2'd1;
  assign target_nx  = (res_req & (res_take | ~run)) ? norm : target;
  assign blank_done = (state == S_BLANK) & frame_start & blank_tc;
  assign run_back   = blank_done & (target_nx == resolution_code);
  hdmi_sched_frame_cnt #(.MOD(FRAMES_PER_PATTERN)) u_rot (
    .clk(clk), .rst_n(sys_rst_n), .en(fs_ok & auto_en), .clr(advance | run_back), .tc(rot_tc)
  );
  hdmi_sched_frame_cnt #(.MOD(BLANK_FRAMES)) u_blank (
    .clk(clk), .rst_n(sys_rst_n), .en((state == S_BLANK) & frame_start), .clr(state == S_TGRST), .tc(blank_tc)
  );
  always_comb begin
    state_nx = state;
    idx_nx   = advance ? idx_adv : idx;
    cs_nx    = cs;
    res_nx   = resolution_code;
    trst_nx  = timing_rst_n;
    busy_nx  = busy;
    pend_nx  = advance ? 1'b0 : (pend | next_req | keep_adv);
    rcnt_nx  = rcnt;
    case (state)
      S_RUN: begin
        cs_nx    = pattern_cs(idx_nx);
        trst_nx  = 1'b1;
        busy_nx  = res_take;
        state_nx = res_take ? S_WAIT : S_RUN;
      end
      S_WAIT: if (frame_start) begin
        cs_nx    = CS_NONE;
        res_nx   = target_nx;
        trst_nx  = 1'b0;
        rcnt_nx  = '0;
        state_nx = S_TGRST;
      end
      S_TGRST: begin
        rcnt_nx = rcnt + 1'b1;
        if (rcnt == RW'(TG_RST_CYCLES - 1)) begin
          trst_nx  = 1'b1;
          state_nx = S_BLANK;
        end
      end
      default: begin
        cs_nx = CS_NONE;
        if (blank_done) begin
          state_nx = run_back ? S_RUN : S_WAIT;
          cs_nx    = run_back ? pattern_cs(idx) : CS_NONE;
          busy_nx  = ~run_back;
        end
      end
    endcase
  end
  always_ff @(posedge clk)
    if (!sys_rst_n) begin
      state           <= S_RUN;
      idx             <= 2'd0;
      cs              <= CS_COLORBAR;
      resolution_code <= RES_640x480;
      target          <= RES_640x480;
      timing_rst_n    <= 1'b0;
      busy            <= 1'b0;
      pend            <= 1'b0;
      rcnt            <= '0;
    end else begin
      state           <= state_nx;
      idx             <= idx_nx;
      cs              <= cs_nx;
      resolution_code <= res_nx;
      target          <= target_nx;
      timing_rst_n    <= trst_nx;
      busy            <= busy_nx;
      pend            <= pend_nx;
      rcnt            <= rcnt_nx;
    end
endmodule

// File: tb/tb_hdmi_pattern_sched.sv
// tb_hdmi_pattern_sched: scoreboard bench; expectations queued with a due cycle and checked after each edge.
module tb_hdmi_pattern_sched;
  localparam int K_CS = 0, K_RES = 1, K_TRST = 2, K_BUSY = 3;
  typedef struct {int due; string tag; int kind; int val;} exp_t;
  logic clk = 1'b0, sys_rst_n, frame_start, auto_en, next_req, res_req;
  logic [1:0] res_code_in, resolution_code;
  logic [3:0] cs;
  logic timing_rst_n, busy;
`ifdef HDMI_SCHED_HOLD_EN
  logic hold;
`endif
  exp_t q[$];
  int cyc = 0, checks = 0, failures = 0;
  hdmi_pattern_sched #(
    .FRAMES_PER_PATTERN(3), .NUM_PATTERNS(4), .BLANK_FRAMES(2), .TG_RST_CYCLES(4)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .frame_start(frame_start), .auto_en(auto_en),
    .next_req(next_req), .res_req(res_req), .res_code_in(res_code_in),
`ifdef HDMI_SCHED_HOLD_EN
    .hold(hold),
`endif
    .cs(cs), .resolution_code(resolution_code), .timing_rst_n(timing_rst_n), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int pat(input int i);
    int t[4] = '{9, 10, 11, 12};
    return t[i % 4];
  endfunction
  function automatic int obs(input int kind);
    return kind == K_CS ? int'(cs) : kind == K_RES ? int'(resolution_code) : kind == K_TRST ? int'(timing_rst_n) : int'(busy);
  endfunction
  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask
  task automatic push(input string tag, input int kind, input int val);
    exp_t e;
    e.due = cyc + 1; e.tag = tag; e.kind = kind; e.val = val;
    q.push_back(e);
  endtask
  task automatic drain();
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      check(e.tag, obs(e.kind), e.val);
    end
  endtask
  task automatic clk1(input logic fs, input logic nr, input logic rr, input logic [1:0] code);
    frame_start = fs; next_req = nr; res_req = rr; res_code_in = code;
    @(posedge clk); #1;
    frame_start = 0; next_req = 0; res_req = 0;
    drain();
  endtask
  task automatic idle(input int n);
    repeat (n) clk1(0, 0, 0, 2'b00);
  endtask
  task automatic frame();
    clk1(1, 0, 0, 2'b00);
    idle(2);
  endtask
  task automatic switch_to(input logic [1:0] code, input int want_res, input int want_cs);
    push("sw_busy", K_BUSY, 1);
    clk1(0, 0, 1, code);
    idle(1);
    frame();
    idle(4);
    frame();
    push("sw_done_cs", K_CS, want_cs); push("sw_done_busy", K_BUSY, 0); push("sw_done_res", K_RES, want_res);
    frame();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    sys_rst_n = 0; auto_en = 0; frame_start = 0; next_req = 0; res_req = 0; res_code_in = 0;
`ifdef HDMI_SCHED_HOLD_EN
    hold = 0;
`endif
    idle(2);
    push("rst_cs", K_CS, 9); push("rst_res", K_RES, 0); push("rst_trst", K_TRST, 0); push("rst_busy", K_BUSY, 0);
    idle(1);
    sys_rst_n = 1;
    push("rel_trst", K_TRST, 1);
    idle(1);
    auto_en = 1;
    for (int k = 1; k <= 12; k++) begin
      push($sformatf("auto%0d", k), K_CS, pat(k / 3));
      frame();
    end
    auto_en = 0;
    push("nr_mid", K_CS, 9);
    clk1(0, 1, 0, 2'b00);
    idle(1);
    push("nr_apply", K_CS, 10);
    frame();
    push("nr_coinc", K_CS, 11);
    clk1(1, 1, 0, 2'b00);
    idle(2);
    auto_en = 1;
    push("tc_pre1", K_CS, 11); frame();
    push("tc_pre2", K_CS, 11); frame();
    push("tc_nr_single", K_CS, 12);
    clk1(1, 1, 0, 2'b00);
    idle(2);
    auto_en = 0;
    push("tc_no_extra", K_CS, 12); frame();
    push("sw_busy1", K_BUSY, 1); push("sw_cs_kept", K_CS, 12);
    clk1(0, 0, 1, 2'b01);
    idle(1);
    push("sw_cs0", K_CS, 0); push("sw_res01", K_RES, 1); push("sw_trst_e0", K_TRST, 0);
    clk1(1, 0, 0, 2'b00);
    for (int i = 1; i <= 3; i++) begin
      push($sformatf("sw_trst_e%0d", i), K_TRST, 0);
      idle(1);
    end
    push("sw_trst_rise", K_TRST, 1);
    idle(1);
    push("blank1_cs", K_CS, 0); push("blank1_busy", K_BUSY, 1);
    frame();
    push("back_cs", K_CS, 12); push("back_busy", K_BUSY, 0); push("back_res", K_RES, 1);
    frame();
    switch_to(2'b00, 0, 12);
    clk1(0, 0, 1, 2'b01);
    idle(1);
    frame();
    idle(4);
    push("late_busy", K_BUSY, 1);
    clk1(0, 0, 1, 2'b10);
    frame();
    push("rewait_cs", K_CS, 0); push("rewait_busy", K_BUSY, 1); push("rewait_res", K_RES, 1);
    frame();
    push("late_res", K_RES, 2);
    frame();
    idle(4);
    frame();
    push("late_cs", K_CS, 12); push("late_done_busy", K_BUSY, 0); push("late_done_res", K_RES, 2);
    frame();
    switch_to(2'b11, 0, 12);
    push("ign_busy", K_BUSY, 0); push("ign_res", K_RES, 0);
    clk1(0, 0, 1, 2'b11);
    push("ign_busy2", K_BUSY, 0);
    idle(1);
    clk1(0, 0, 1, 2'b01);
    idle(1);
    clk1(1, 0, 0, 2'b00);
    idle(1);
    sys_rst_n = 0;
    push("mrst_cs", K_CS, 9); push("mrst_res", K_RES, 0); push("mrst_trst", K_TRST, 0); push("mrst_busy", K_BUSY, 0);
    idle(1);
    sys_rst_n = 1;
    push("mrst_trst_rise", K_TRST, 1); push("mrst_busy2", K_BUSY, 0);
    idle(1);
    push("mrst_run_cs", K_CS, 9); push("mrst_run_busy", K_BUSY, 0);
    frame();
`ifdef HDMI_SCHED_HOLD_EN
    auto_en = 1;
    push("hold_pre", K_CS, 9); frame();
    hold = 1;
    for (int k = 1; k <= 5; k++) begin
      push($sformatf("hold%0d", k), K_CS, 9);
      frame();
    end
    hold = 0;
    push("hold_rel1", K_CS, 9); frame();
    push("hold_rel2", K_CS, 10); frame();
`endif
    idle(2);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
